// File: rtl/rf_writeback_queue_pkg.sv
// Shared register-file definitions: data/address widths, register count, queue entry layout.
// No logic; constants and types only.
// Used by the writeback queue, its forwarder and anything that talks to the register file.
package rf_writeback_queue_pkg;

  localparam int RF_DW    = 16;
  localparam int RF_AW    = 4;
  localparam int RF_NREGS = 16;

  // One queued register result: destination register and value.
  typedef struct packed {
    logic [RF_AW-1:0] rd;
    logic [RF_DW-1:0] data;
  } rf_entry_t;

  localparam int RF_ENTRY_W = RF_AW + RF_DW;

endpackage

// File: rtl/rf_wbq_fwd.sv
// Youngest-match forwarder: returns the newest occupied queue entry for addr, else register-file data.
// Latency: purely combinational.
// Backpressure: none; it only observes queue state.
module rf_wbq_fwd
  import rf_writeback_queue_pkg::*;
#(
  parameter int DW    = RF_DW,
  parameter int AW    = RF_AW,
  parameter int DEPTH = 4
) (
  input  logic [AW-1:0]                addr,
  input  logic [DW-1:0]                rf_data,
  input  logic [DEPTH-1:0][AW-1:0]     ent_rd,
  input  logic [DEPTH-1:0][DW-1:0]     ent_data,
  input  logic [DEPTH-1:0]             ent_vld,
  input  logic [$clog2(DEPTH)-1:0]     head,
  output logic [DW-1:0]                fwd_data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk entries from oldest (head) to youngest; the last match wins.
  always_comb begin
    fwd_data = rf_data;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + i[PW-1:0];
      if (ent_vld[idx] && (ent_rd[idx] == addr)) begin
        fwd_data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/rf_writeback_queue.sv
// Buffers long-latency register results and retires them on cycles the write port is free; forwards them to reads.
// Latency: an accepted result can be written and forwarded from the next cycle.
// Backpressure: in_ready = !full from registered count only; a pop in the same cycle does not free a slot.
module rf_writeback_queue
  import rf_writeback_queue_pkg::*;
#(
  parameter int DW    = RF_DW,
  parameter int AW    = RF_AW,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_rd,
  input  logic [DW-1:0]              in_data,
  input  logic                       port_free,
  output logic                       wr,
  output logic [AW-1:0]              rw,
  output logic [DW-1:0]              val,
  input  logic [AW-1:0]              ra,
  input  logic [AW-1:0]              rb,
  input  logic [DW-1:0]              rav_rf,
  input  logic [DW-1:0]              rbv_rf,
  output logic [DW-1:0]              rav,
  output logic [DW-1:0]              rbv,
  output logic [$clog2(DEPTH):0]     pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][AW-1:0] ent_rd;
  logic [DEPTH-1:0][DW-1:0] ent_data;
  logic [DEPTH-1:0]         ent_vld;
  logic [PW-1:0]            head;
  logic [PW-1:0]            tail;
  logic [CW-1:0]            count;
  logic                     push;

  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign wr       = port_free && (count != '0);
  assign rw       = wr ? ent_rd[head]   : '0;
  assign val      = wr ? ent_data[head] : '0;
  assign pending  = count;

  // Occupancy mask: slot k is live when its distance from head is below count.
  for (genvar k = 0; k < DEPTH; k++) begin : g_vld
    logic [PW-1:0] off;
    assign off        = PW'(k) - head;
    assign ent_vld[k] = ({1'b0, off} < count);
  end

  // Entry storage; contents need no reset because count gates every use.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd[tail]   <= in_rd;
      ent_data[tail] <= in_data;
    end
  end

  // Pointers and occupancy; reset drops queued results without writing them back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (wr)   head <= head + PW'(1);
      case ({push, wr})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  rf_wbq_fwd #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_fwd_a (
    .addr     (ra),
    .rf_data  (rav_rf),
    .ent_rd   (ent_rd),
    .ent_data (ent_data),
    .ent_vld  (ent_vld),
    .head     (head),
    .fwd_data (rav)
  );

  rf_wbq_fwd #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_fwd_b (
    .addr     (rb),
    .rf_data  (rbv_rf),
    .ent_rd   (ent_rd),
    .ent_data (ent_data),
    .ent_vld  (ent_vld),
    .head     (head),
    .fwd_data (rbv)
  );

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Self-checking bench for rf_writeback_queue with a scoreboard of queued results.
// Inputs change just after the falling edge; outputs are checked 1 time unit later.
// Expected writes, occupancy and forwarded data all come from the bench's own queue model.
module tb_rf_writeback_queue;
  import rf_writeback_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rd;
  logic [15:0] in_data;
  logic        port_free;
  logic        wr;
  logic [3:0]  rw;
  logic [15:0] val;
  logic [3:0]  ra, rb;
  logic [15:0] rav_rf, rbv_rf;
  logic [15:0] rav, rbv;
  logic [2:0]  pending;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;
  logic [15:0] dut_rf [16];
  rf_entry_t   sb[$];

  always #5 clk = ~clk;

  rf_writeback_queue #(.DW(16), .AW(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .port_free(port_free), .wr(wr), .rw(rw), .val(val),
    .ra(ra), .rb(rb), .rav_rf(rav_rf), .rbv_rf(rbv_rf),
    .rav(rav), .rbv(rbv), .pending(pending)
  );

  // Register file stand-in capturing what the queue actually writes.
  always @(posedge clk) begin
    if (wr) begin
      dut_rf[rw] <= val;
      n_wr       <= n_wr + 1;
    end
  end

  // One clock of scoreboard checking and model update with the currently applied inputs.
  task automatic tick();
    int n;
    logic exp_wr;
    logic [15:0] exp_a, exp_b;
    rf_entry_t e;
    #1;
    n = sb.size();
    exp_wr = port_free && (n != 0);
    n_cmp++; if (wr !== exp_wr) begin n_bad++; $display("FAIL wr: got %b expected %b", wr, exp_wr); end
    n_cmp++; if (in_ready !== (n < DEPTH)) begin n_bad++; $display("FAIL in_ready: got %b expected %b", in_ready, (n < DEPTH)); end
    n_cmp++; if (pending !== 3'(n)) begin n_bad++; $display("FAIL pending: got %0d expected %0d", pending, n); end
    if (exp_wr) begin
      n_cmp++; if (rw !== sb[0].rd) begin n_bad++; $display("FAIL rw: got %h expected %h", rw, sb[0].rd); end
      n_cmp++; if (val !== sb[0].data) begin n_bad++; $display("FAIL val: got %h expected %h", val, sb[0].data); end
    end else if (n == 0) begin
      n_cmp++; if ({rw, val} !== 20'h0) begin n_bad++; $display("FAIL rw_val_idle: got %h/%h expected 0/0", rw, val); end
    end
    exp_a = rav_rf;
    exp_b = rbv_rf;
    foreach (sb[i]) begin
      if (sb[i].rd == ra) exp_a = sb[i].data;
      if (sb[i].rd == rb) exp_b = sb[i].data;
    end
    n_cmp++; if (rav !== exp_a) begin n_bad++; $display("FAIL rav: got %h expected %h", rav, exp_a); end
    n_cmp++; if (rbv !== exp_b) begin n_bad++; $display("FAIL rbv: got %h expected %h", rbv, exp_b); end
    if (exp_wr) void'(sb.pop_front());
    if (in_valid && (n < DEPTH)) begin
      e.rd   = in_rd;
      e.data = in_data;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0; port_free = 1'b1;
    ra = 4'd2; rav_rf = 16'h1234; rb = 4'd7; rbv_rf = 16'h5678;
    #2;
    n_cmp++; if (pending !== 3'd0) begin n_bad++; $display("FAIL rst_pending: got %0d expected 0", pending); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (wr !== 1'b0) begin n_bad++; $display("FAIL rst_wr: got %b expected 0", wr); end
    n_cmp++; if ({rw, val} !== 20'h0) begin n_bad++; $display("FAIL rst_rw_val: got %h/%h expected 0/0", rw, val); end
    n_cmp++; if (rav !== 16'h1234) begin n_bad++; $display("FAIL rst_rav: got %h expected 1234", rav); end
    n_cmp++; if (rbv !== 16'h5678) begin n_bad++; $display("FAIL rst_rbv: got %h expected 5678", rbv); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_single();
    port_free = 1'b0; in_valid = 1'b1; in_rd = 4'd3; in_data = 16'h00AA;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    n_cmp++; if (pending !== 3'd1) begin n_bad++; $display("FAIL single_hold: got %0d expected 1", pending); end
    port_free = 1'b1;
    #1;
    n_cmp++; if ({wr, rw, val} !== {1'b1, 4'd3, 16'h00AA}) begin n_bad++; $display("FAIL single_write: got %b/%h/%h expected 1/3/00aa", wr, rw, val); end
    tick();
    #1;
    n_cmp++; if ({wr, pending} !== {1'b0, 3'd0}) begin n_bad++; $display("FAIL single_after: got %b/%0d expected 0/0", wr, pending); end
    @(negedge clk);
  endtask

  task automatic test_full();
    port_free = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_rd = 4'(8 + i); in_data = 16'(16'h0100 + i);
      tick();
    end
    n_cmp++; if ({in_ready, pending} !== {1'b0, 3'd4}) begin n_bad++; $display("FAIL full_state: got %b/%0d expected 0/4", in_ready, pending); end
    in_rd = 4'd12; in_data = 16'hDEAD;
    tick();
    port_free = 1'b1; in_rd = 4'd13; in_data = 16'hBEEF;
    tick();
    n_cmp++; if (pending !== 3'd3) begin n_bad++; $display("FAIL full_pop_no_push: got %0d expected 3", pending); end
    in_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_forward();
    port_free = 1'b0; ra = 4'd5; rb = 4'd6; rav_rf = 16'hBEEF; rbv_rf = 16'hCAFE;
    in_valid = 1'b1; in_rd = 4'd5; in_data = 16'h0011;
    tick();
    in_data = 16'h0022;
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (rav !== 16'h0022) begin n_bad++; $display("FAIL fwd_both: got %h expected 0022", rav); end
    port_free = 1'b1;
    tick();
    #1;
    n_cmp++; if (rav !== 16'h0022) begin n_bad++; $display("FAIL fwd_one: got %h expected 0022", rav); end
    tick();
    port_free = 1'b0;
    #1;
    n_cmp++; if (rav !== 16'hBEEF) begin n_bad++; $display("FAIL fwd_none: got %h expected beef", rav); end
    n_cmp++; if (dut_rf[5] !== 16'h0022) begin n_bad++; $display("FAIL fwd_rf5: got %h expected 0022", dut_rf[5]); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    port_free = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_rd = 4'(9 + i); in_data = 16'(16'h0200 + i);
      tick();
    end
    port_free = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_rd = 4'(i); in_data = 16'(16'h0300 + i);
      tick();
      n_cmp++; if (pending !== 3'd2) begin n_bad++; $display("FAIL b2b_pending: got %0d expected 2", pending); end
    end
    in_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      port_free = ($urandom_range(0, 2) != 0);
      in_rd     = 4'($urandom_range(0, 15));
      in_data   = 16'($urandom);
      ra        = 4'($urandom_range(0, 15));
      rb        = 4'($urandom_range(0, 15));
      rav_rf    = 16'($urandom);
      rbv_rf    = 16'($urandom);
      tick();
    end
    in_valid = 1'b0; port_free = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_async_reset();
    int w0;
    port_free = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_rd = 4'(1 + i); in_data = 16'(16'h0400 + i);
      tick();
    end
    in_valid = 1'b0; port_free = 1'b1;
    #2;
    w0 = n_wr;
    rst = 1'b1;
    #1;
    n_cmp++; if ({wr, pending, in_ready} !== {1'b0, 3'd0, 1'b1}) begin n_bad++; $display("FAIL arst_now: got %b/%0d/%b expected 0/0/1", wr, pending, in_ready); end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    n_cmp++; if (n_wr !== w0) begin n_bad++; $display("FAIL arst_no_write: got %0d writes expected %0d", n_wr, w0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_forward();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
